// File: rtl/ins_cache_nway_if.sv
// Command and next-level bus of the N-way instruction cache.
// The master side issues trace commands and acknowledges line reads; the cache is the slave.
interface ins_cache_nway_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 6
);
    logic [3:0]                  n;
    logic [ADDR_W-1:0]           add_in;
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [ADDR_W-LINE_BITS-1:0] add_out;
    logic [1:0]                  cmd_out;
    logic                        fill_ack;

    modport master (
        output n, add_in, cmd_valid, fill_ack,
        input  cmd_ready, add_out, cmd_out
    );

    modport slave (
        input  n, add_in, cmd_valid, fill_ack,
        output cmd_ready, add_out, cmd_out
    );
endinterface

// File: rtl/ins_cache_nway.sv
// Parametrised N-way set-associative instruction cache with true-LRU ages and a post-reset flush sweep.
// Optional eviction counter port enabled by defining ICACHE_EVICT_CNT_EN.
module ins_cache_nway #(
    parameter int WAYS      = 4,
    parameter int SET_BITS  = 14,
    parameter int LINE_BITS = 6,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    ins_cache_nway_if.slave   bus,
    output logic [31:0]       hit,
    output logic [31:0]       miss,
    output logic [31:0]       reads
`ifdef ICACHE_EVICT_CNT_EN
    ,
    output logic [31:0]       evicts
`endif
);
    localparam int SETS     = 2 ** SET_BITS;
    localparam int TAG_BITS = ADDR_W - SET_BITS - LINE_BITS;
    localparam int WAY_W    = $clog2(WAYS);

    localparam logic [3:0] CMD_FETCH = 4'd2;
    localparam logic [3:0] CMD_INVAL = 4'd3;
    localparam logic [3:0] CMD_RESET = 4'd8;
    localparam logic [1:0] OUT_NOP   = 2'b00;
    localparam logic [1:0] OUT_READ  = 2'b01;

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_FILL_WAIT} state_t;

    state_t              state;
    logic [SET_BITS-1:0] flush_idx;

    logic                valid_mem [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_mem   [SETS][WAYS];
    logic [WAY_W-1:0]    age_mem   [SETS][WAYS];

    logic [SET_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tg;
    logic                accept;
    logic                unused_offset;

    assign idx           = bus.add_in[SET_BITS+LINE_BITS-1:LINE_BITS];
    assign tg            = bus.add_in[ADDR_W-1:SET_BITS+LINE_BITS];
    assign unused_offset = ^bus.add_in[LINE_BITS-1:0];
    assign bus.cmd_ready = (state == S_IDLE);
    assign accept        = bus.cmd_valid && (state == S_IDLE);

    logic             hit_any;
    logic             inv_any;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] promote_way;
    logic [WAY_W-1:0] promote_age;
    logic [WAY_W-1:0] new_age [WAYS];

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        hit_any = 1'b0;
        inv_any = 1'b0;
        hit_way = '0;
        inv_way = '0;
        lru_way = '0;
        // Scanning downwards lets the lowest-index way win every tie.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[idx][w] && tag_mem[idx][w] == tg) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_mem[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_mem[idx][w] == WAY_W'(WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        victim      = inv_any ? inv_way : lru_way;
        promote_way = hit_any ? hit_way : victim;
        promote_age = age_mem[idx][promote_way];
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == promote_way) begin
                new_age[w] = '0;
            end else if (age_mem[idx][w] < promote_age) begin
                new_age[w] = age_mem[idx][w] + 1'b1;
            end else begin
                new_age[w] = age_mem[idx][w];
            end
        end
    end

    // NOTE: the set arrays have no reset; the FLUSH sweep initialises them one set per cycle.
    always_ff @(posedge clk) begin
        if (state == S_FLUSH) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_mem[flush_idx][w] <= 1'b0;
                tag_mem[flush_idx][w]   <= '0;
                age_mem[flush_idx][w]   <= WAY_W'(WAYS - 1 - w);
            end
        end else if (accept) begin
            if (bus.n == CMD_INVAL && hit_any) begin
                valid_mem[idx][hit_way] <= 1'b0;
            end else if (bus.n == CMD_FETCH) begin
                if (!hit_any) begin
                    valid_mem[idx][victim] <= 1'b1;
                    tag_mem[idx][victim]   <= tg;
                end
                for (int w = 0; w < WAYS; w++) begin
                    age_mem[idx][w] <= new_age[w];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FLUSH;
            flush_idx   <= '0;
            hit         <= '0;
            miss        <= '0;
            reads       <= '0;
`ifdef ICACHE_EVICT_CNT_EN
            evicts      <= '0;
`endif
            bus.cmd_out <= OUT_NOP;
            bus.add_out <= '0;
        end else begin
            case (state)
                S_FLUSH: begin
                    flush_idx <= flush_idx + 1'b1;
                    if (flush_idx == '1) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.n)
                            CMD_RESET: begin
                                hit       <= '0;
                                miss      <= '0;
                                reads     <= '0;
`ifdef ICACHE_EVICT_CNT_EN
                                evicts    <= '0;
`endif
                                flush_idx <= '0;
                                state     <= S_FLUSH;
                            end
                            CMD_FETCH: begin
                                reads <= reads + 32'd1;
                                if (hit_any) begin
                                    hit <= hit + 32'd1;
                                end else begin
                                    miss        <= miss + 32'd1;
`ifdef ICACHE_EVICT_CNT_EN
                                    if (!inv_any) begin
                                        evicts <= evicts + 32'd1;
                                    end
`endif
                                    bus.cmd_out <= OUT_READ;
                                    bus.add_out <= bus.add_in[ADDR_W-1:LINE_BITS];
                                    state       <= S_FILL_WAIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_FILL_WAIT: begin
                    if (bus.fill_ack) begin
                        bus.cmd_out <= OUT_NOP;
                        bus.add_out <= '0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_FLUSH;
            endcase
        end
    end
endmodule

// File: tb/tb_ins_cache_nway.sv
// Self-checking bench for ins_cache_nway: directed scenarios plus random traffic
// checked against a timestamp-based LRU model of the cache.
module tb_ins_cache_nway;
    localparam int WAYS      = 4;
    localparam int SET_BITS  = 2;
    localparam int LINE_BITS = 6;
    localparam int ADDR_W    = 32;
    localparam int SETS      = 1 << SET_BITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hit;
    logic [31:0] miss;
    logic [31:0] reads;
`ifdef ICACHE_EVICT_CNT_EN
    logic [31:0] evicts;
`endif

    ins_cache_nway_if #(.ADDR_W(ADDR_W), .LINE_BITS(LINE_BITS)) bus ();

    ins_cache_nway #(
        .WAYS(WAYS), .SET_BITS(SET_BITS), .LINE_BITS(LINE_BITS), .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .hit   (hit),
        .miss  (miss),
        .reads (reads)
`ifdef ICACHE_EVICT_CNT_EN
        ,
        .evicts(evicts)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-way valid/tag plus a last-use timestamp; LRU = oldest stamp.
    bit          m_valid [SETS][WAYS];
    int          m_tag   [SETS][WAYS];
    int          m_stamp [SETS][WAYS];
    int          m_time;
    int unsigned m_hit, m_miss, m_reads, m_evicts;

    function automatic void model_flush();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = 0;
                m_stamp[s][w] = w - WAYS;
            end
        end
        m_time = 0;
    endfunction

    function automatic void model_reset();
        model_flush();
        m_hit = 0; m_miss = 0; m_reads = 0; m_evicts = 0;
    endfunction

    // Applies one accepted command; returns 1 when a line read is expected.
    function automatic bit model_apply(input logic [3:0] code, input logic [31:0] addr);
        int s = int'((addr >> LINE_BITS) % SETS);
        int t = int'(addr >> (LINE_BITS + SET_BITS));
        int found = -1;
        int vic = -1;
        for (int w = WAYS - 1; w >= 0; w--)
            if (m_valid[s][w] && m_tag[s][w] == t) found = w;
        case (code)
            4'd8: begin
                model_reset();
                return 1'b0;
            end
            4'd3: begin
                if (found >= 0) m_valid[s][found] = 1'b0;
                return 1'b0;
            end
            4'd2: begin
                m_reads++;
                m_time++;
                if (found >= 0) begin
                    m_hit++;
                    m_stamp[s][found] = m_time;
                    return 1'b0;
                end
                m_miss++;
                for (int w = WAYS - 1; w >= 0; w--)
                    if (!m_valid[s][w]) vic = w;
                if (vic < 0) begin
                    m_evicts++;
                    vic = 0;
                    for (int w = 1; w < WAYS; w++)
                        if (m_stamp[s][w] < m_stamp[s][vic]) vic = w;
                end
                m_valid[s][vic] = 1'b1;
                m_tag[s][vic]   = t;
                m_stamp[s][vic] = m_time;
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit"},   hit,   m_hit);
        check({tag, "_miss"},  miss,  m_miss);
        check({tag, "_reads"}, reads, m_reads);
`ifdef ICACHE_EVICT_CNT_EN
        check({tag, "_evicts"}, evicts, m_evicts);
`endif
    endtask

    task automatic wait_flush(input string tag);
        int c = 0;
        while (!bus.cmd_ready && c < 50) begin
            tick();
            c++;
        end
        check(tag, c, SETS);
    endtask

    // Offers one command, then services the line read after `stall` cycles of fill_ack low.
    task automatic send(input logic [3:0] code, input logic [31:0] addr, input int stall, input bit offer);
        int  waitc = 0;
        bit  exp_read;
        while (!bus.cmd_ready && waitc < 100) begin
            tick();
            waitc++;
        end
        if (waitc >= 100) check("ready_timeout", bus.cmd_ready, 1);
        exp_read      = model_apply(code, addr);
        bus.n         = code;
        bus.add_in    = addr;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        if (exp_read) begin
            check("rd_cmd",   bus.cmd_out, 2'b01);
            check("rd_addr",  bus.add_out, addr >> LINE_BITS);
            check("rd_ready", bus.cmd_ready, 0);
            for (int k = 0; k < stall; k++) begin
                if (offer) begin
                    bus.n         = 4'd2;
                    bus.add_in    = $urandom;
                    bus.cmd_valid = 1'b1;
                end
                tick();
                check("stall_cmd",   bus.cmd_out, 2'b01);
                check("stall_addr",  bus.add_out, addr >> LINE_BITS);
                check("stall_ready", bus.cmd_ready, 0);
            end
            bus.cmd_valid = 1'b0;
            bus.fill_ack  = 1'b1;
            tick();
            bus.fill_ack  = 1'b0;
            check("ack_cmd",   bus.cmd_out, 2'b00);
            check("ack_addr",  bus.add_out, 0);
            check("ack_ready", bus.cmd_ready, 1);
        end else if (code == 4'd8) begin
            check("reset_ready", bus.cmd_ready, 0);
            wait_flush("reset_flush_len");
        end else begin
            check("nop_cmd",   bus.cmd_out, 2'b00);
            check("nop_ready", bus.cmd_ready, 1);
        end
        check_counters("cnt");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  code;
        int          r;
        int unsigned reads_before;

        bus.n = 4'd0; bus.add_in = '0; bus.cmd_valid = 1'b0; bus.fill_ack = 1'b0;
        model_reset();

        // Flush after reset.
        repeat (3) tick();
        check("rst_cmd_out", bus.cmd_out, 2'b00);
        check("rst_add_out", bus.add_out, 0);
        check("rst_ready",   bus.cmd_ready, 0);
        rst = 1'b0;
        wait_flush("flush_len");
        check_counters("rst");

        // Cold miss then hit.
        send(4'd2, 32'h0000_1040, 5, 1'b0);
        check("cold_miss", miss, 1);
        send(4'd2, 32'h0000_1040, 0, 1'b0);
        check("warm_hit",   hit,   1);
        check("warm_reads", reads, 2);

        // LRU eviction within set 1.
        send(4'd8, 32'h0, 0, 1'b0);
        check("clr_reads", reads, 0);
        send(4'd2, 32'h0000_0140, 1, 1'b0);
        send(4'd2, 32'h0000_0240, 0, 1'b0);
        send(4'd2, 32'h0000_0340, 2, 1'b0);
        send(4'd2, 32'h0000_0440, 0, 1'b0);
        send(4'd2, 32'h0000_0140, 0, 1'b0);
        send(4'd2, 32'h0000_0540, 0, 1'b0);
        send(4'd2, 32'h0000_0240, 0, 1'b0);
        send(4'd2, 32'h0000_0140, 0, 1'b0);
        check("lru_miss",  miss,  6);
        check("lru_hit",   hit,   2);
        check("lru_reads", reads, 8);
`ifdef ICACHE_EVICT_CNT_EN
        check("lru_evicts", evicts, 2);
`endif

        // Invalidate a present line, then an absent one.
        send(4'd2, 32'h0000_0140, 0, 1'b0);
        send(4'd3, 32'h0000_0140, 0, 1'b0);
        send(4'd2, 32'h0000_0140, 0, 1'b0);
        check("inval_refetch_miss", miss, 7);
        send(4'd3, 32'h0000_0940, 0, 1'b0);
        send(4'd2, 32'h0000_0540, 0, 1'b0);
        check("inval_absent_hit", hit, 4);

        // Fill stall with a command offered while stalled.
        reads_before = reads;
        send(4'd2, 32'h0000_2080, 10, 1'b1);
        check("stall_reads_once", reads, reads_before + 1);

        // Reset in the middle of a fill.
        while (!bus.cmd_ready) tick();
        void'(model_apply(4'd2, 32'h0000_AB80));
        bus.n = 4'd2; bus.add_in = 32'h0000_AB80; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        check("midfill_read", bus.cmd_out, 2'b01);
        tick();
        #2 rst = 1'b1;
        #1;
        check("midfill_async_nop", bus.cmd_out, 2'b00);
        check("midfill_ready",     bus.cmd_ready, 0);
        model_reset();
        check_counters("midfill");
        tick();
        rst = 1'b0;
        wait_flush("midfill_flush_len");

        // Random traffic against the model.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      code = 4'd2;
            else if (r < 85) code = 4'd3;
            else if (r < 97) code = 4'(($urandom_range(0, 1) == 0) ? 9 : $urandom_range(0, 1));
            else             code = 4'd8;
            a = {21'($urandom_range(0, 7)), 3'd0, 2'($urandom_range(0, SETS - 1)), 6'($urandom)};
            if ($urandom_range(0, 9) == 0 && bus.cmd_ready) begin
                bus.fill_ack = 1'b1;
                tick();
                bus.fill_ack = 1'b0;
            end
            send(code, a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
